// File: rtl/mac_pkg.sv
// Shared opcodes, default widths and the accumulator-width helper
// for the pipelined multiply-accumulate datapath.
package mac_pkg;

  localparam int W_DEF = 16;
  localparam int G_DEF = 8;

  localparam logic [2:0] OP_MUL  = 3'b000;
  localparam logic [2:0] OP_MAC  = 3'b001;
  localparam logic [2:0] OP_MSC  = 3'b010;
  localparam logic [2:0] OP_MACS = 3'b011;
  localparam logic [2:0] OP_CLR  = 3'b100;
  localparam logic [2:0] OP_RD   = 3'b101;

  function automatic int acc_width(input int w, input int g);
    return 2 * w + g;
  endfunction

endpackage

// File: rtl/mac_pipe_if.sv
// Issue/result bus of the MAC pipeline; master issues operations,
// slave (the MAC) returns results.
interface mac_pipe_if
  import mac_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int G = G_DEF
);
  logic                stall;
  logic                in_valid;
  logic [2:0]          instruction;
  logic signed [W-1:0] multiplier;
  logic signed [W-1:0] multiplicand;
  logic                out_valid;
  logic [2*W-1:0]      result;
  logic [G-1:0]        protect;
  logic                sat;

  modport master (
    output stall, in_valid, instruction, multiplier, multiplicand,
    input  out_valid, result, protect, sat
  );

  modport slave (
    input  stall, in_valid, instruction, multiplier, multiplicand,
    output out_valid, result, protect, sat
  );
endinterface

// File: rtl/mac_sat.sv
// Combinational clamp of a wide signed accumulator to the signed 2W range,
// with a flag raised whenever clamping happened.
module mac_sat
  import mac_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int G = G_DEF
) (
  input  logic [acc_width(W, G)-1:0] acc_in,
  output logic [2*W-1:0]             sat_result,
  output logic                       sat_flag
);
  localparam int AW = acc_width(W, G);

  logic [AW-2*W:0] top_bits;
  logic            in_range;

  // The value fits in 2W bits exactly when the guard bits and the 2W sign bit agree.
  assign top_bits = acc_in[AW-1:2*W-1];
  assign in_range = (&top_bits) | ~(|top_bits);

  always_comb begin
    sat_result = acc_in[2*W-1:0];
    sat_flag   = 1'b0;
    if (!in_range) begin
      sat_flag = 1'b1;
      if (acc_in[AW-1]) begin
        sat_result = {1'b1, {(2*W-1){1'b0}}};
      end else begin
        sat_result = {1'b0, {(2*W-1){1'b1}}};
      end
    end
  end

endmodule

// File: rtl/mac_pipe.sv
// Three-stage signed multiply-accumulate: operand register, product register,
// accumulator/result register. A global stall freezes every stage.
module mac_pipe
  import mac_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int G = G_DEF
) (
  input logic       clk,
  input logic       reset_n,
  mac_pipe_if.slave bus
);
  localparam int AW = acc_width(W, G);

  logic                  s1_valid_reg;
  logic [2:0]            s1_op_reg;
  logic signed [W-1:0]   s1_a_reg;
  logic signed [W-1:0]   s1_b_reg;

  logic                  s2_valid_reg;
  logic [2:0]            s2_op_reg;
  logic signed [2*W-1:0] s2_prod_reg;

  logic [AW-1:0]         acc_reg;
  logic [2*W-1:0]        result_reg;
  logic                  sat_reg;
  logic                  out_valid_reg;

  logic [AW-1:0]         prod_ext;
  logic [AW-1:0]         acc_next;
  logic [2*W-1:0]        sat_result;
  logic                  sat_flag;
  logic                  is_macs;

  // Stage 1: capture the issued operation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_reg <= 1'b0;
      s1_op_reg    <= '0;
      s1_a_reg     <= '0;
      s1_b_reg     <= '0;
    end else if (!bus.stall) begin
      s1_valid_reg <= bus.in_valid;
      s1_op_reg    <= bus.instruction;
      s1_a_reg     <= bus.multiplier;
      s1_b_reg     <= bus.multiplicand;
    end
  end

  // Stage 2: full-precision signed product.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid_reg <= 1'b0;
      s2_op_reg    <= '0;
      s2_prod_reg  <= '0;
    end else if (!bus.stall) begin
      s2_valid_reg <= s1_valid_reg;
      s2_op_reg    <= s1_op_reg;
      s2_prod_reg  <= s1_a_reg * s1_b_reg;
    end
  end

  assign prod_ext = {{G{s2_prod_reg[2*W-1]}}, s2_prod_reg};
  assign is_macs  = (s2_op_reg == OP_MACS);

  // Accumulator feedback stays inside stage 3, so dependent ops issue back to back.
  always_comb begin
    acc_next = acc_reg;
    case (s2_op_reg)
      OP_MUL:  acc_next = prod_ext;
      OP_MAC:  acc_next = acc_reg + prod_ext;
      OP_MSC:  acc_next = acc_reg - prod_ext;
      OP_MACS: acc_next = acc_reg + prod_ext;
      OP_CLR:  acc_next = '0;
      default: acc_next = acc_reg;
    endcase
  end

  mac_sat #(
    .W (W),
    .G (G)
  ) u_sat (
    .acc_in     (acc_next),
    .sat_result (sat_result),
    .sat_flag   (sat_flag)
  );

  // Stage 3: accumulator and outputs; outputs hold while no operation completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_reg       <= '0;
      result_reg    <= '0;
      sat_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
    end else if (!bus.stall) begin
      out_valid_reg <= s2_valid_reg;
      if (s2_valid_reg) begin
        acc_reg    <= acc_next;
        result_reg <= is_macs ? sat_result : acc_next[2*W-1:0];
        sat_reg    <= is_macs & sat_flag;
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.result    = result_reg;
  assign bus.protect   = acc_reg[AW-1:2*W];
  assign bus.sat       = sat_reg;

endmodule

// File: tb/tb_mac_pipe.sv
// Directed bench for mac_pipe (W=16, G=8) with hand-computed expectations.
module tb_mac_pipe;
  import mac_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   checks = 0;
  int   passed = 0;

  mac_pipe_if #(.W(16), .G(8)) bus ();

  mac_pipe #(.W(16), .G(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [2:0] op, input logic signed [15:0] a, input logic signed [15:0] b);
    bus.in_valid     = 1'b1;
    bus.instruction  = op;
    bus.multiplier   = a;
    bus.multiplicand = b;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.stall = 1'b0; bus.in_valid = 1'b0; bus.instruction = '0;
    bus.multiplier = '0; bus.multiplicand = '0;
    #1 reset_n = 1'b0;
    #2;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.out_valid); else passed++;
    checks++; if (bus.result !== 32'h0) $display("FAIL reset_result: got %h want 00000000", bus.result); else passed++;
    checks++; if (bus.protect !== 8'h0) $display("FAIL reset_protect: got %h want 00", bus.protect); else passed++;
    checks++; if (bus.sat !== 1'b0) $display("FAIL reset_sat: got %b want 0", bus.sat); else passed++;
    #10 reset_n = 1'b1;
    $display("reset: checked outputs cleared");
  endtask

  task automatic test_mul();
    set_op(OP_MUL, 16'sd3, -16'sd4); tick();
    idle(); tick();
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL mul_early_valid: got %b want 0", bus.out_valid); else passed++;
    tick();
    checks++; if (bus.out_valid !== 1'b1) $display("FAIL mul_valid: got %b want 1", bus.out_valid); else passed++;
    checks++; if (bus.result !== 32'hFFFFFFF4) $display("FAIL mul_result: got %h want FFFFFFF4", bus.result); else passed++;
    checks++; if (bus.protect !== 8'hFF) $display("FAIL mul_protect: got %h want FF", bus.protect); else passed++;
    checks++; if (bus.sat !== 1'b0) $display("FAIL mul_sat: got %b want 0", bus.sat); else passed++;
    tick();
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL mul_single_valid: got %b want 0", bus.out_valid); else passed++;
    checks++; if (bus.result !== 32'hFFFFFFF4) $display("FAIL mul_hold: got %h want FFFFFFF4", bus.result); else passed++;
    $display("mul: 3 * -4 result=%h protect=%h", bus.result, bus.protect);
  endtask

  task automatic test_back_to_back();
    set_op(OP_MUL, 16'sd100, 16'sd100); tick();
    set_op(OP_MAC, 16'sd200, 16'sd50); tick();
    set_op(OP_MSC, 16'sd10, 16'sd10); tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.result !== 32'd10000) $display("FAIL b2b_0: got v=%b %0d want v=1 10000", bus.out_valid, bus.result); else passed++;
    idle(); tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.result !== 32'd20000) $display("FAIL b2b_1: got v=%b %0d want v=1 20000", bus.out_valid, bus.result); else passed++;
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.result !== 32'd19900) $display("FAIL b2b_2: got v=%b %0d want v=1 19900", bus.out_valid, bus.result); else passed++;
    checks++; if (bus.protect !== 8'h00) $display("FAIL b2b_protect: got %h want 00", bus.protect); else passed++;
    tick();
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL b2b_end_valid: got %b want 0", bus.out_valid); else passed++;
    $display("back_to_back: final result=%0d", bus.result);
  endtask

  task automatic test_guard();
    set_op(OP_MUL, -16'sd32768, -16'sd32768); tick();
    set_op(OP_MAC, -16'sd32768, -16'sd32768); tick();
    set_op(OP_MAC, -16'sd32768, -16'sd32768); tick();
    checks++; if (bus.result !== 32'h40000000) $display("FAIL guard_0: got %h want 40000000", bus.result); else passed++;
    set_op(OP_MACS, 16'sd0, 16'sd0); tick();
    checks++; if (bus.result !== 32'h80000000) $display("FAIL guard_1: got %h want 80000000", bus.result); else passed++;
    idle(); tick();
    checks++; if (bus.result !== 32'hC0000000) $display("FAIL guard_2: got %h want C0000000", bus.result); else passed++;
    checks++; if (bus.protect !== 8'h00) $display("FAIL guard_protect: got %h want 00", bus.protect); else passed++;
    checks++; if (bus.sat !== 1'b0) $display("FAIL guard_mac_sat: got %b want 0", bus.sat); else passed++;
    tick();
    checks++; if (bus.result !== 32'h7FFFFFFF) $display("FAIL macs_result: got %h want 7FFFFFFF", bus.result); else passed++;
    checks++; if (bus.sat !== 1'b1) $display("FAIL macs_sat: got %b want 1", bus.sat); else passed++;
    checks++; if (bus.protect !== 8'h00) $display("FAIL macs_protect: got %h want 00", bus.protect); else passed++;
    tick();
    $display("guard: macs result=%h protect=%h", bus.result, bus.protect);
  endtask

  task automatic test_stall();
    set_op(OP_MUL, 16'sd1, 16'sd1); tick();
    set_op(OP_MAC, 16'sd2, 16'sd3); tick();
    set_op(OP_MAC, 16'sd4, 16'sd5); tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.result !== 32'd1) $display("FAIL stall_r0: got v=%b %0d want v=1 1", bus.out_valid, bus.result); else passed++;
    set_op(OP_MAC, -16'sd6, 16'sd7);
    bus.stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (bus.out_valid !== 1'b1 || bus.result !== 32'd1) $display("FAIL stall_frozen%0d: got v=%b %0d want v=1 1", i, bus.out_valid, bus.result); else passed++;
    end
    bus.stall = 1'b0; tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.result !== 32'd7) $display("FAIL stall_r1: got v=%b %0d want v=1 7", bus.out_valid, bus.result); else passed++;
    idle(); tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.result !== 32'd27) $display("FAIL stall_r2: got v=%b %0d want v=1 27", bus.out_valid, bus.result); else passed++;
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.result !== 32'hFFFFFFF1) $display("FAIL stall_r3: got v=%b %h want v=1 FFFFFFF1", bus.out_valid, bus.result); else passed++;
    checks++; if (bus.protect !== 8'hFF) $display("FAIL stall_protect: got %h want FF", bus.protect); else passed++;
    tick();
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL stall_no_dup: got %b want 0", bus.out_valid); else passed++;
    $display("stall: last result=%h", bus.result);
  endtask

  task automatic test_reset_inflight();
    set_op(OP_MAC, 16'sd1, 16'sd1); tick();
    set_op(OP_MAC, 16'sd1, 16'sd1); tick();
    idle();
    reset_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.result !== 32'h0) $display("FAIL rst_fly_out: got v=%b %h want v=0 00000000", bus.out_valid, bus.result); else passed++;
    checks++; if (bus.protect !== 8'h0 || bus.sat !== 1'b0) $display("FAIL rst_fly_flags: got p=%h s=%b want p=00 s=0", bus.protect, bus.sat); else passed++;
    #2 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_fly_quiet%0d: got %b want 0", i, bus.out_valid); else passed++;
    end
    set_op(OP_MAC, 16'sd2, 16'sd3); tick();
    idle(); tick();
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_fly_early: got %b want 0", bus.out_valid); else passed++;
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.result !== 32'd6) $display("FAIL rst_fly_first: got v=%b %0d want v=1 6", bus.out_valid, bus.result); else passed++;
    tick();
    $display("reset_inflight: first result after reset=%0d", bus.result);
  endtask

  task automatic test_bubbles_opcodes();
    set_op(OP_MSC, 16'sd1, 16'sd10); tick();
    idle(); tick(); tick();
    checks++; if (bus.result !== 32'hFFFFFFFC || bus.protect !== 8'hFF) $display("FAIL bub_msc: got %h p=%h want FFFFFFFC p=FF", bus.result, bus.protect); else passed++;
    tick(); tick();
    set_op(OP_RD, 16'sd5, 16'sd5); tick();
    set_op(3'b110, 16'sd5, 16'sd5); tick();
    set_op(3'b111, 16'sd5, 16'sd5); tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.out_valid !== 1'b1 || bus.result !== 32'hFFFFFFFC) $display("FAIL bub_rd%0d: got v=%b %h want v=1 FFFFFFFC", i, bus.out_valid, bus.result); else passed++;
      tick();
    end
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL bub_rd_end: got %b want 0", bus.out_valid); else passed++;
    set_op(OP_CLR, 16'sd7, 16'sd7); tick();
    idle(); tick(); tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.result !== 32'h0) $display("FAIL clr_result: got v=%b %h want v=1 00000000", bus.out_valid, bus.result); else passed++;
    checks++; if (bus.protect !== 8'h00) $display("FAIL clr_protect: got %h want 00", bus.protect); else passed++;
    tick();
    $display("bubbles_opcodes: after clr result=%h", bus.result);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_mul();
    test_back_to_back();
    test_guard();
    test_stall();
    test_reset_inflight();
    test_bubbles_opcodes();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mac_pipe.md
# mac_pipe

Parametrised, pipelined signed multiply-accumulate unit with an instruction-selected accumulate mode, guard-bit overflow protection, optional output saturation, global stall and valid tracking. It is the next-generation datapath MAC. It accepts one multiply operation per cycle, keeps a wide accumulator, and presents a registered result three cycles after issue.

## Interface
- W, 16, operand width in bits (signed); result width is 2W.
- G, 8, guard bits; accumulator width AW = 2W+G.
- clk  in  1  clock, rising edge.
- reset_n  in  1  reset; asynchronous, active-low.
- stall  in  1  freezes every pipeline register, including outputs.
- in_valid  in  1  the current instruction and operands are an operation.
- instruction  in  3  opcode, see Operation.
- multiplier  in  W  signed operand A.
- multiplicand  in  W  signed operand B.
- out_valid  out  1  the result, protect and sat outputs carry a completed operation.
- result  out  2W  low 2W bits of the accumulator, or the saturated value for MACS.
- protect  out  G  accumulator bits [AW-1:2W] (guard bits).
- sat  out  1  the result was clamped (MACS only).

## Operation
- p = A*B, full-precision signed product (2W bits), sign-extended to AW.
- Opcodes:
  - 000 MUL: acc = p.
  - 001 MAC: acc = acc + p.
  - 010 MSC: acc = acc − p.
  - 011 MACS: acc = acc + p; result is clamped to the signed 2W range.
  - 100 CLR: acc = 0.
  - 101 RD: acc unchanged (readback).
  - 110 and 111: reserved; behave as RD.
- Accumulator arithmetic wraps modulo 2^AW. No other overflow handling.
- Saturation for MACS:
  - If acc > 2^(2W−1)−1: result = 0x7FF..F, sat = 1.
  - If acc < −2^(2W−1): result = 0x800..0, sat = 1.
  - Otherwise result = acc[2W−1:0], sat = 0.
  - The accumulator itself keeps the unclamped value.
- protect always equals acc[AW−1:2W], for every opcode including MACS.
- sat = 0 for all non-MACS operations.
- Every operation with in_valid = 1 produces exactly one out_valid, including CLR, RD and reserved opcodes.
- Operations with in_valid = 0 are bubbles: they do not change acc and produce no out_valid.

## Timing
- Issue: the operation is sampled at rising edge k when in_valid = 1 and stall = 0.
- Stage 1 (edge k): operands, opcode and valid are registered.
- Stage 2 (edge k+1): product p is registered.
- Stage 3 (edge k+2): acc, result, protect, sat and out_valid are updated. Latency is 3 edges.
- Accumulator feedback is local to stage 3. Back-to-back dependent MAC/MSC operations run at full rate with no hazard.
- stall = 1: no register changes, including out_valid. The operation presented at that edge is not sampled.
- A consumer counts a result only when out_valid = 1 and stall = 0. This gives no loss and no duplication across stalls.
- Outputs hold their last values while out_valid = 0.
- Reset (asynchronous): all stages, acc, result, protect, sat and out_valid go to 0 immediately. In-flight operations are discarded.
- After reset release, the first out_valid appears 3 edges after the first issue.
- stall and reset asserted together: reset wins.

## Structure
- Package mac_pkg:
  - Opcode constants: OP_MUL, OP_MAC, OP_MSC, OP_MACS, OP_CLR, OP_RD.
  - Default W and G.
  - Function computing AW.
- Sub-module mac_sat: combinational clamp of an AW-bit signed value to 2W bits, plus the sat flag. Instantiated once in stage 3.
- All other logic stays in mac_pipe: three stage register banks, opcode decode and accumulator update.

## Test plan
All values assume W=16, G=8.
- Single MUL, 3 × −4 → 3 edges later: out_valid = 1, result = 0xFFFFFFF4, protect = 0xFF, sat = 0.
- Back-to-back chain MUL 100×100, MAC 200×50, MSC 10×10 → results 10000, 20000, 19900 on three consecutive cycles.
- Guard overflow: MUL (−32768)×(−32768), then MAC the same operands twice → result 0xC0000000, protect 0x00. A following MACS 0×0 → result 0x7FFFFFFF, sat = 1, protect 0x00.
- Stall: issue 4 MAC operations with stall high for 2 cycles in the middle → all outputs frozen during stall; 4 results delivered in order with correct running sums, none lost or duplicated.
- Reset with 2 operations in flight → all outputs 0 immediately; no out_valid after release until a new issue plus 3 edges.
- Bubbles and opcodes: in_valid = 0 gaps and opcodes 101/110/111 leave acc unchanged (readback shows the previous sum). CLR → result 0, protect 0.
